mul_unit: RTL
=============

MUL_UNIT -- requirements
Module: mul_unit

Interface
REQ-001 SHALL have parameter WIDTH_P, default WORD_SIZE_P, operand and result width.
REQ-002 SHALL have parameter LAT_P, default 3, valid_i-to-cdb_v_o latency in cycles; fixed at 3 for this revision.
REQ-003 SHALL have port clk_i, input, 1, sole clock; all state on its rising edge.
REQ-004 SHALL have port reset_n_i, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port valid_i, input, 1, issue strobe, driven from the issue table's valid_o[FU_MUL].
REQ-006 SHALL have port instruction_i, input, issued_instruction_t, the issued instruction; sampled only when valid_i=1.
REQ-007 SHALL have port flush_i, input, 1, mispredict kill of all in-flight work.
REQ-008 SHALL have port cdb_o, output, CDB_t, result broadcast; drives one slot of the cdb[NUM_FU] array.
REQ-009 SHALL have port cdb_v_o, output, 1, cdb_o carries a live result.
REQ-010 SHALL have port busy_o, output, 1, any pipeline stage holds a live operation.

Function
REQ-011 SHALL accept an operation every cycle valid_i=1; no ready output, no backpressure, no stalls.
REQ-012 SHALL operate as a 3-stage pipeline: S1 registers operands/opcode/tags, S2 registers the 2*WIDTH_P product, S3 registers result and flags into cdb_o.
REQ-013 SHALL assert cdb_v_o exactly 3 cycles after the valid_i=1 cycle, for exactly 1 cycle per operation.
REQ-014 SHALL preserve issue order; back-to-back inputs produce back-to-back outputs.
REQ-015 SHALL use source_1_data as operand A and source2_imm_data as operand B (already immediate-resolved).
REQ-016 SHALL decode opcode: OP_MUL gives the low WIDTH_P bits; OP_MULHU gives the high bits, unsigned*unsigned; OP_MULHS gives the high bits, signed*signed.
REQ-017 SHALL produce result 0 with flags 0 for any other opcode, and still write back.
REQ-018 SHALL set flags: N = result MSB; Z = (result==0); C = upper half nonzero (OP_MUL only, else 0); V = signed product does not fit WIDTH_P (OP_MUL only, else 0).
REQ-019 SHALL carry dest_id to cdb_o.dest, rob_dest to cdb_o.rob_dest and pc to cdb_o.pc unchanged.
REQ-020 SHALL drive cdb_o.dest = NULL_TAG whenever cdb_v_o=0, so no issue-table entry can tag-match an idle bus.
REQ-021 SHALL on flush_i=1 clear the valid bits of S1, S2 and S3, and discard valid_i in the same cycle; cdb_v_o=0 the next cycle.
REQ-022 SHALL, when flush_i and a same-cycle S3 output coincide, still present that cycle's cdb_v_o (it is already registered); only later outputs are killed.
REQ-023 SHALL set busy_o = OR of the S1/S2/S3 valid bits.
REQ-024 SHALL gate datapath registers by their stage valid; idle stages hold their value.

Reset
REQ-025 SHALL on reset_n_i=0 immediately clear all stage valids: cdb_v_o=0, busy_o=0, cdb_o.dest=NULL_TAG, other cdb_o fields 0.
REQ-026 SHALL drop any operation in flight when reset asserts mid-operation; no output after release.
REQ-027 SHALL accept valid_i on the first rising edge after reset_n_i deasserts.

Structure
REQ-028 SHALL place OP_MUL, OP_MULHU, OP_MULHS, FU_MUL, NULL_TAG, CDB_t and issued_instruction_t in Purple_Jade_pkg.
REQ-029 SHALL define NULL_TAG with a bit set above $clog2(NUM_PHYS_REG)-1, so that it lies outside the physical tag range.
REQ-030 SHALL use one sub-module, mul_core (signed/unsigned 2*WIDTH_P multiplier with a registered output, forming S2); all other logic stays in mul_unit.

Verification
REQ-031 SHALL cover: OP_MUL A=0x0003, B=0x0005, dest 7 at cycle 0 -> cdb_v_o=1 at cycle 3, result 0x000F, dest 7, Z=0, C=0.
REQ-032 SHALL cover: OP_MULHS A=0xFFFF, B=0x0002 -> result 0xFFFF, N=1; OP_MULHU with the same operands -> result 0x0001, N=0.
REQ-033 SHALL cover: OP_MUL A=0x0100, B=0x0100 -> result 0x0000, Z=1, C=1, V=1.
REQ-034 SHALL cover: valid_i high for 4 cycles, dest 1,2,3,4 -> cdb_v_o high cycles 3-6 with dest 1,2,3,4 in order.
REQ-035 SHALL cover: ops issued at cycles 0 and 1, flush_i=1 at cycle 2 -> no cdb_v_o at cycles 3-4, busy_o=0 at cycle 3, dest=NULL_TAG throughout.
REQ-036 SHALL cover: op issued at cycle 0, reset_n_i low mid-cycle 1 -> cdb_v_o=0 immediately and no output after release.

Source files
------------

// File: rtl/Purple_Jade_pkg.sv
// Purple_Jade_pkg: shared core types (tags, opcodes, issue and CDB records) used by the functional units.
package Purple_Jade_pkg;
  localparam int WORD_SIZE_P = 16;
  localparam int NUM_PHYS_REG = 32;
  localparam int NUM_FU = 4;
  localparam int ROB_SIZE = 16;
  localparam int TAG_W = $clog2(NUM_PHYS_REG) + 1;
  localparam int ROB_W = $clog2(ROB_SIZE);
  typedef logic [TAG_W-1:0] tag_t;
  // The extra top bit places NULL_TAG outside every physical register tag.
  localparam tag_t NULL_TAG = {1'b1, {(TAG_W-1){1'b0}}};
  typedef enum logic [1:0] {FU_ALU, FU_MUL, FU_MEM, FU_BR} fu_e;
  typedef enum logic [3:0] {
    OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR,
    OP_MUL, OP_MULHU, OP_MULHS
  } opcode_e;
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;
  typedef struct packed {
    opcode_e opcode;
    tag_t dest_id;
    logic [ROB_W-1:0] rob_dest;
    logic [31:0] pc;
    logic [WORD_SIZE_P-1:0] source_1_data;
    logic [WORD_SIZE_P-1:0] source2_imm_data;
  } issued_instruction_t;
  typedef struct packed {
    tag_t dest;
    logic [ROB_W-1:0] rob_dest;
    logic [31:0] pc;
    logic [WORD_SIZE_P-1:0] result;
    flags_t flags;
  } CDB_t;
endpackage

// File: rtl/mul_core.sv
// mul_core: registered 2*WIDTH_P multiplier producing both unsigned and signed products.
//   clk_i, reset_n_i : clock, async active-low reset
//   en_i             : load the product registers (idle cycles hold)
//   a_i, b_i         : operands
//   prod_u_o         : unsigned a*b
//   prod_s_o         : signed a*b
module mul_core #(
  parameter int WIDTH_P = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 en_i,
  input  logic [WIDTH_P-1:0]   a_i,
  input  logic [WIDTH_P-1:0]   b_i,
  output logic [2*WIDTH_P-1:0] prod_u_o,
  output logic [2*WIDTH_P-1:0] prod_s_o
);
  logic [2*WIDTH_P-1:0] prod_u_d, prod_s_d, prod_u_q, prod_s_q;
  assign prod_u_d = {{WIDTH_P{1'b0}}, a_i} * {{WIDTH_P{1'b0}}, b_i};
  // Sign-extending to full width makes the modular product equal the signed product.
  assign prod_s_d = {{WIDTH_P{a_i[WIDTH_P-1]}}, a_i} * {{WIDTH_P{b_i[WIDTH_P-1]}}, b_i};
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      prod_u_q <= '0;
      prod_s_q <= '0;
    end else if (en_i) begin
      prod_u_q <= prod_u_d;
      prod_s_q <= prod_s_d;
    end
  assign prod_u_o = prod_u_q;
  assign prod_s_o = prod_s_q;
endmodule

// File: rtl/mul_unit.sv
// mul_unit: 3-stage pipelined multiply functional unit broadcasting onto one CDB slot.
//   clk_i, reset_n_i : clock, async active-low reset
//   valid_i          : issue strobe
//   instruction_i    : issued instruction (sampled when valid_i)
//   flush_i          : kill all in-flight operations
//   cdb_o, cdb_v_o   : result broadcast and its valid
//   busy_o           : any stage holds a live operation
module mul_unit
  import Purple_Jade_pkg::*;
#(
  parameter int WIDTH_P = WORD_SIZE_P,
  parameter int LAT_P = 3
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                valid_i,
  input  issued_instruction_t instruction_i,
  input  logic                flush_i,
  output CDB_t                cdb_o,
  output logic                cdb_v_o,
  output logic                busy_o
);
  logic [LAT_P-1:0] v_q, v_d;
  issued_instruction_t s1_q;
  opcode_e s2_op_q;
  tag_t s2_dest_q;
  logic [ROB_W-1:0] s2_rob_q;
  logic [31:0] s2_pc_q;
  logic [2*WIDTH_P-1:0] prod_u, prod_s;
  logic [WIDTH_P-1:0] res;
  logic is_lo, is_mul;
  CDB_t cdb_q, cdb_d;
  // Stage valids shift one bit per cycle: bit 0 is S1, bit LAT_P-1 is S3.
  assign v_d = flush_i ? '0 : {v_q[LAT_P-2:0], valid_i};
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) v_q <= '0;
    else v_q <= v_d;
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) s1_q <= '0;
    else if (valid_i) s1_q <= instruction_i;
  mul_core #(.WIDTH_P(WIDTH_P)) u_core (
    .clk_i(clk_i),
    .reset_n_i(reset_n_i),
    .en_i(v_q[0]),
    .a_i(s1_q.source_1_data),
    .b_i(s1_q.source2_imm_data),
    .prod_u_o(prod_u),
    .prod_s_o(prod_s)
  );
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      s2_op_q <= OP_NOP;
      s2_dest_q <= '0;
      s2_rob_q <= '0;
      s2_pc_q <= '0;
    end else if (v_q[0]) begin
      s2_op_q <= s1_q.opcode;
      s2_dest_q <= s1_q.dest_id;
      s2_rob_q <= s1_q.rob_dest;
      s2_pc_q <= s1_q.pc;
    end
  assign is_lo = s2_op_q == OP_MUL;
  assign is_mul = is_lo || s2_op_q == OP_MULHU || s2_op_q == OP_MULHS;
  assign res = is_lo ? prod_u[WIDTH_P-1:0]
             : s2_op_q == OP_MULHU ? prod_u[2*WIDTH_P-1:WIDTH_P]
             : s2_op_q == OP_MULHS ? prod_s[2*WIDTH_P-1:WIDTH_P]
             : '0;
  // Overflow: the signed product differs from its own low half sign-extended.
  always_comb begin
    cdb_d = '0;
    cdb_d.dest = s2_dest_q;
    cdb_d.rob_dest = s2_rob_q;
    cdb_d.pc = s2_pc_q;
    cdb_d.result = res;
    cdb_d.flags.n = is_mul & res[WIDTH_P-1];
    cdb_d.flags.z = is_mul & ~|res;
    cdb_d.flags.c = is_lo & |prod_u[2*WIDTH_P-1:WIDTH_P];
    cdb_d.flags.v = is_lo & (prod_s != {{WIDTH_P{prod_s[WIDTH_P-1]}}, prod_s[WIDTH_P-1:0]});
  end
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) cdb_q <= '0;
    else if (v_q[1]) cdb_q <= cdb_d;
  assign cdb_v_o = v_q[LAT_P-1];
  assign busy_o = |v_q;
  always_comb begin
    cdb_o = cdb_q;
    cdb_o.dest = cdb_v_o ? cdb_q.dest : NULL_TAG;
  end
endmodule
